// File: rtl/i2c_cfg_tx.sv
// I2C write-only master: START, NBYTES bytes MSB-first with ACK slots, STOP.
// Every line change happens on a quarter-period tick; SDA is open-drain.
module i2c_cfg_tx #(
    parameter int QDIV   = 125,
    parameter int NBYTES = 3
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  GO,
    input  logic [8*NBYTES-1:0]   DATA,
    output logic                  END,
    output logic                  ACK_ERR,
    output logic                  I2C_SCLK,
    inout  wire                   I2C_SDAT
);
    localparam int DW = 8 * NBYTES;
    localparam int QW = $clog2(QDIV);
    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

    state_t          state;
    logic [QW-1:0]   qcnt;
    logic [1:0]      q;
    logic [2:0]      bitcnt;
    logic [BW-1:0]   bytecnt;
    logic [DW-1:0]   sr;
    logic            sda_lo;
    logic            tick;

    assign tick     = (state != IDLE) && (qcnt == QW'(QDIV - 1));
    assign I2C_SDAT = sda_lo ? 1'b0 : 1'bz;

    // Outputs are updated on the tick that enters the next quarter.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            qcnt     <= '0;
            q        <= 2'd0;
            bitcnt   <= 3'd7;
            bytecnt  <= '0;
            sr       <= '0;
            sda_lo   <= 1'b0;
            END      <= 1'b1;
            ACK_ERR  <= 1'b0;
            I2C_SCLK <= 1'b1;
        end else begin
            if (state == IDLE || tick) qcnt <= '0;
            else                       qcnt <= qcnt + 1'b1;

            if (state == IDLE) begin
                if (GO) begin
                    sr      <= DATA;
                    ACK_ERR <= 1'b0;
                    END     <= 1'b0;
                    state   <= START;
                    q       <= 2'd0;
                    bitcnt  <= 3'd7;
                    bytecnt <= '0;
                end
            end else if (tick) begin
                q <= q + 2'd1;
                case (state)
                    START: case (q)
                        2'd1: sda_lo <= 1'b1;
                        2'd2: I2C_SCLK <= 1'b0;
                        2'd3: begin
                            state  <= BIT;
                            sda_lo <= ~sr[DW-1];
                        end
                        default: ;
                    endcase
                    BIT: case (q)
                        2'd1: I2C_SCLK <= 1'b1;
                        2'd3: begin
                            I2C_SCLK <= 1'b0;
                            sr       <= {sr[DW-2:0], 1'b0};
                            if (bitcnt == 3'd0) begin
                                state  <= ACK;
                                sda_lo <= 1'b0;
                            end else begin
                                bitcnt <= bitcnt - 3'd1;
                                sda_lo <= ~sr[DW-2];
                            end
                        end
                        default: ;
                    endcase
                    ACK: case (q)
                        2'd1: I2C_SCLK <= 1'b1;
                        2'd2: if (I2C_SDAT) ACK_ERR <= 1'b1;
                        2'd3: begin
                            I2C_SCLK <= 1'b0;
                            if (bytecnt == BW'(NBYTES - 1)) begin
                                state  <= STOP;
                                sda_lo <= 1'b1;
                            end else begin
                                bytecnt <= bytecnt + 1'b1;
                                bitcnt  <= 3'd7;
                                state   <= BIT;
                                sda_lo  <= ~sr[DW-1];
                            end
                        end
                        default: ;
                    endcase
                    STOP: case (q)
                        2'd0: I2C_SCLK <= 1'b1;
                        2'd1: sda_lo <= 1'b0;
                        2'd3: begin
                            state <= IDLE;
                            END   <= 1'b1;
                        end
                        default: ;
                    endcase
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_cfg_tx.sv
// Scoreboard bench for i2c_cfg_tx: stimulus pushes expected transactions,
// a bus monitor with a slave ACK model decodes the wires and compares.
module tb_i2c_cfg_tx;
    localparam int Q   = 2;
    localparam int Q2  = 125;
    localparam int LAT = (4 + 36 * 3 + 4) * Q;

    logic        clk = 1'b0, rst_n = 1'b0, go = 1'b0, go2 = 1'b0;
    logic [23:0] data = '0, data2 = '0;
    logic        end_o, ack_err, sclk, end2, ack_err2, sclk2;
    wire         sdat, sdat2;
    logic        slv_drv = 1'b0;
    logic [2:0]  nack_mask = '0;

    pullup (sdat);
    pullup (sdat2);
    assign sdat = slv_drv ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_cfg_tx #(.QDIV(Q), .NBYTES(3)) dut (
        .CLOCK(clk), .RESET(rst_n), .GO(go), .DATA(data), .END(end_o),
        .ACK_ERR(ack_err), .I2C_SCLK(sclk), .I2C_SDAT(sdat));

    i2c_cfg_tx #(.QDIV(Q2), .NBYTES(3)) dut2 (
        .CLOCK(clk), .RESET(rst_n), .GO(go2), .DATA(data2), .END(end2),
        .ACK_ERR(ack_err2), .I2C_SCLK(sclk2), .I2C_SDAT(sdat2));

    typedef struct { logic [23:0] data; logic err; } exp_t;
    exp_t expq[$];
    int   nchk = 0, npass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor + slave: decode bits on SCL rise, ACK byte i unless nack_mask[i].
    logic        pscl = 1'b1, psda = 1'b1, pend = 1'b1, busy = 1'b0;
    int          lowcnt, nstart, nstop, nrise;
    logic [23:0] cap;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy    = 1'b0;
                slv_drv = 1'b0;
            end else begin
                if (pend && !end_o) begin
                    busy = 1'b1; lowcnt = 0; nstart = 0; nstop = 0; nrise = 0; cap = '0;
                end
                if (busy) begin
                    if (!end_o) lowcnt++;
                    if (sclk && pscl && psda && !sdat) nstart++;
                    if (sclk && pscl && !psda && sdat) nstop++;
                    if (sclk && !pscl) begin
                        if (nrise < 27 && nrise % 9 != 8) cap = {cap[22:0], sdat};
                        nrise++;
                    end
                    if (!sclk && pscl) begin
                        if (slv_drv) slv_drv = 1'b0;
                        else if (nrise < 27 && nrise % 9 == 8) slv_drv = !nack_mask[nrise / 9];
                    end
                    if (!pend && end_o) begin
                        busy = 1'b0;
                        if (expq.size() == 0) chk("unexpected_txn", 32'(expq.size()), 1);
                        else begin
                            e = expq.pop_front();
                            chk("tx_bytes", 32'(cap), 32'(e.data));
                            chk("ack_err", 32'(ack_err), 32'(e.err));
                            chk("end_low_cycles", lowcnt, LAT);
                            chk("framing_start_stop_rises", {8'd0, nstart[7:0], nstop[7:0], nrise[7:0]},
                                {8'd0, 8'd1, 8'd1, 8'd28});
                        end
                    end
                end
            end
            pscl = sclk; psda = sdat; pend = end_o;
        end
    end

    task automatic push_exp(input logic [23:0] d, input logic [2:0] m);
        exp_t e;
        e.data = d;
        e.err  = (m != 3'b000);
        expq.push_back(e);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!end_o && n < 2000) begin @(negedge clk); n++; end
        if (!end_o) chk("end_timeout", 32'(end_o), 1);
    endtask

    task automatic send(input logic [23:0] d, input logic [2:0] m);
        @(negedge clk);
        wait_end();
        data = d; nack_mask = m; go = 1'b1;
        push_exp(d, m);
        @(posedge clk); #1 go = 1'b0;
        wait_end();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad, hi;
        int low2, hichg, r1, r2, t;
        logic ps, pd;
        logic [23:0] d;
        logic [2:0]  m;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_end", 32'(end_o), 1);
        chk("rst_ack_err", 32'(ack_err), 0);
        chk("rst_sclk", 32'(sclk), 1);
        chk("rst_sdat", 32'(sdat), 1);
        rst_n = 1'b1;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (end_o !== 1'b1 || sclk !== 1'b1 || sdat !== 1'b1 || ack_err !== 1'b0) bad++;
        end
        chk("idle_stable", bad, 0);

        send(24'h340C00, 3'b000);
        send(24'h340EC2, 3'b010);
        send(24'h34AA55, 3'b000);

        // GO held high across two transactions, DATA changed mid-transfer.
        @(negedge clk);
        wait_end();
        data = 24'h341201; nack_mask = 3'b000; go = 1'b1;
        push_exp(24'h341201, 3'b000);
        push_exp(24'h340838, 3'b000);
        @(posedge clk);
        repeat (50) @(posedge clk);
        #1 data = 24'h340838;
        wait_end();
        hi = 0;
        while (end_o && hi < 10) begin hi++; @(negedge clk); end
        chk("b2b_end_high", hi, 1);
        go = 1'b0;
        wait_end();

        for (int i = 0; i < 8; i++) begin
            d = 24'($urandom);
            m = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            send(d, m);
        end

        // Reset during the third bit of the second byte.
        @(negedge clk);
        data = 24'h34ABCD; nack_mask = 3'b000; go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        repeat (50 * Q) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_end", 32'(end_o), 1);
        chk("midrst_sclk", 32'(sclk), 1);
        chk("midrst_sdat", 32'(sdat), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send(24'h341000, 3'b000);

        // Full-rate instance: no slave attached, so every ACK slot reads high.
        @(negedge clk);
        data2 = 24'h340C00; go2 = 1'b1;
        @(posedge clk); #1 go2 = 1'b0;
        low2 = 0; hichg = 0; r1 = -1; r2 = -1; t = 0;
        ps = sclk2; pd = sdat2;
        while (!end2 && t < 20000) begin
            @(negedge clk);
            t++;
            if (!end2) low2++;
            if (sclk2 && ps && (sdat2 !== pd)) hichg++;
            if (sclk2 && !ps) begin
                if (r1 < 0) r1 = t;
                else if (r2 < 0) r2 = t;
            end
            ps = sclk2; pd = sdat2;
        end
        chk("q125_end_low_cycles", low2, 116 * Q2);
        chk("q125_scl_period", r2 - r1, 4 * Q2);
        chk("q125_sda_changes_scl_high", hichg, 2);
        chk("q125_ack_err", 32'(ack_err2), 1);

        chk("queue_empty", 32'(expq.size()), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
